// File: rtl/solve_pkg.sv
// solve_pkg -- items shared by the solve sequencer and its watchdog.
//   state_t      : sequencer phase encoding. It is exported directly on the
//                  phase port, so the values must not change.
//   ESC_BYTE     : received byte that clears a FAULT.
//   DEFAULT_*    : default board limits, FIFO word width and watchdog limit.
//   dim_in_range : 1 <= value <= limit check used on parsed board dimensions.
package solve_pkg;

  typedef enum logic [1:0] {
    ST_RECEIVE  = 2'd0,
    ST_SOLVE    = 2'd1,
    ST_TRANSMIT = 2'd2,
    ST_FAULT    = 2'd3
  } state_t;

  localparam logic [7:0] ESC_BYTE = 8'h1B;

  localparam int DEFAULT_MAX_ROWS       = 11;
  localparam int DEFAULT_MAX_COLS       = 11;
  localparam int DEFAULT_LINE_W         = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 50_000_000;

  function automatic logic dim_in_range(input int value, input int limit);
    return (value >= 1) && (value <= limit);
  endfunction

endpackage

// File: rtl/phase_watchdog.sv
// phase_watchdog -- cycle counter that flags a phase which has run too long.
//   clk_50mhz : clock
//   rst       : synchronous active-high reset
//   clear     : zero the count (takes priority over enable)
//   enable    : count this cycle
//   expired   : high while enabled and the count is LIMIT-1. The LIMIT-th
//               enabled cycle after a clear is therefore the last one.
// The count holds at LIMIT-1 rather than wrapping, so expired stays asserted
// until the owner clears it.
module phase_watchdog
  import solve_pkg::*;
#(
  parameter int LIMIT = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk_50mhz,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_50mhz) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/solve_sequencer.sv
// solve_sequencer -- phase controller for the board solve flow:
// RECEIVE -> SOLVE -> TRANSMIT -> RECEIVE, with FAULT on a bad board or a
// stalled solve. The ESC byte (8'h1B) clears FAULT.
//
// Build option: define SOLVE_WATCHDOG_EN to build the SOLVE watchdog
// (phase_watchdog). If it is not defined, SOLVE exits only on solved.
//
// Ports
//   clk_50mhz, rst         : clock; synchronous active-high reset
//   rx_valid, rx_byte      : received UART byte strobe and data
//   parsed, parse_m/n      : parser board-complete pulse and board dimensions
//   parse_write/line       : parser FIFO write request (routed in RECEIVE)
//   solve_write/line       : solver FIFO put-back request (routed in SOLVE)
//   solved, assembled      : solver-done and assembler-done pulses
//   fifo_wr_en, fifo_din   : muxed FIFO write port (combinational)
//   solver_start/asm_start : one-cycle pulse in the first SOLVE/TRANSMIT cycle
//   m_lat, n_lat           : board dimensions latched on an accepted board
//   phase                  : current state encoding
//   display                : last received byte
//   fault                  : high while in FAULT
//   boards_done            : completed boards, saturating at 255
module solve_sequencer
  import solve_pkg::*;
#(
  parameter int MAX_ROWS       = DEFAULT_MAX_ROWS,
  parameter int MAX_COLS       = DEFAULT_MAX_COLS,
  parameter int LINE_W         = DEFAULT_LINE_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int M_W = $clog2(MAX_ROWS + 1),
  localparam int N_W = $clog2(MAX_COLS + 1)
) (
  input  logic              clk_50mhz,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic              parsed,
  input  logic [M_W-1:0]    parse_m,
  input  logic [N_W-1:0]    parse_n,
  input  logic              parse_write,
  input  logic [LINE_W-1:0] parse_line,
  input  logic              solve_write,
  input  logic [LINE_W-1:0] solve_line,
  input  logic              solved,
  input  logic              assembled,
  output logic              fifo_wr_en,
  output logic [LINE_W-1:0] fifo_din,
  output logic              solver_start,
  output logic              asm_start,
  output logic [M_W-1:0]    m_lat,
  output logic [N_W-1:0]    n_lat,
  output logic [1:0]        phase,
  output logic [7:0]        display,
  output logic              fault,
  output logic [7:0]        boards_done
);

  state_t state;
  logic   wd_expired;
  logic   dims_ok;

  assign dims_ok = dim_in_range(int'(parse_m), MAX_ROWS) &&
                   dim_in_range(int'(parse_n), MAX_COLS);

`ifdef SOLVE_WATCHDOG_EN
  logic wd_clear;
  logic wd_enable;

  // The watchdog is held clear outside SOLVE, so it reads 0 in the first
  // SOLVE cycle and reaches TIMEOUT_CYCLES-1 in the last cycle allowed.
  assign wd_clear  = (state != ST_SOLVE);
  assign wd_enable = (state == ST_SOLVE);

  phase_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_phase_watchdog (
    .clk_50mhz(clk_50mhz),
    .rst      (rst),
    .clear    (wd_clear),
    .enable   (wd_enable),
    .expired  (wd_expired)
  );
`else
  // No watchdog in this build. The name below keeps the timeout parameter
  // referenced so the parameter list is the same in both builds.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign wd_expired = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments, so every branch
  // below sees the pre-edge values of state and boards_done.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state        <= ST_RECEIVE;
      m_lat        <= '0;
      n_lat        <= '0;
      display      <= '0;
      boards_done  <= '0;
      solver_start <= 1'b0;
      asm_start    <= 1'b0;
      fault        <= 1'b0;
    end else begin
      // The start pulses are set only on the edge that enters their phase.
      solver_start <= 1'b0;
      asm_start    <= 1'b0;

      if (rx_valid) begin
        display <= rx_byte;
      end

      case (state)
        ST_RECEIVE: begin
          if (parsed) begin
            if (dims_ok) begin
              m_lat        <= parse_m;
              n_lat        <= parse_n;
              state        <= ST_SOLVE;
              solver_start <= 1'b1;
            end else begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end
          end
        end

        ST_SOLVE: begin
          // solved is tested first, so it wins over an expiry in the same cycle.
          if (solved) begin
            state     <= ST_TRANSMIT;
            asm_start <= 1'b1;
          end else if (wd_expired) begin
            state <= ST_FAULT;
            fault <= 1'b1;
          end
        end

        ST_TRANSMIT: begin
          if (assembled) begin
            state <= ST_RECEIVE;
            if (boards_done != 8'hFF) begin
              boards_done <= boards_done + 8'd1;
            end
          end
        end

        ST_FAULT: begin
          if (rx_valid && (rx_byte == ESC_BYTE)) begin
            state <= ST_RECEIVE;
            fault <= 1'b0;
          end
        end

        default: begin
          state <= ST_RECEIVE;
          fault <= 1'b0;
        end
      endcase
    end
  end

  assign phase = state;

  // The FIFO write port passes straight through from the phase that owns it.
  // NOTE: both outputs get a default first, so no path through the case
  // leaves them unassigned and no latch is inferred.
  always_comb begin
    fifo_wr_en = 1'b0;
    fifo_din   = '0;
    case (state)
      ST_RECEIVE: begin
        fifo_wr_en = parse_write;
        fifo_din   = parse_line;
      end
      ST_SOLVE: begin
        fifo_wr_en = solve_write;
        fifo_din   = solve_line;
      end
      default: begin
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_solve_sequencer.sv
// tb_solve_sequencer -- bench for solve_sequencer (MAX 11x11, 16-bit words,
// TIMEOUT_CYCLES=100). A phase-level model (phase number plus cycles spent in
// that phase) predicts every output on every cycle. Directed steps add
// hand-computed literal checks. The timeout expectation follows
// SOLVE_WATCHDOG_EN in the same way as the design.
module tb_solve_sequencer;

  localparam int MAX_ROWS = 11;
  localparam int MAX_COLS = 11;
  localparam int LINE_W   = 16;
  localparam int TIMEOUT  = 100;
  localparam int M_W      = $clog2(MAX_ROWS + 1);
  localparam int N_W      = $clog2(MAX_COLS + 1);

`ifdef SOLVE_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic              clk_50mhz = 1'b0;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              parsed;
  logic [M_W-1:0]    parse_m;
  logic [N_W-1:0]    parse_n;
  logic              parse_write;
  logic [LINE_W-1:0] parse_line;
  logic              solve_write;
  logic [LINE_W-1:0] solve_line;
  logic              solved;
  logic              assembled;
  logic              fifo_wr_en;
  logic [LINE_W-1:0] fifo_din;
  logic              solver_start;
  logic              asm_start;
  logic [M_W-1:0]    m_lat;
  logic [N_W-1:0]    n_lat;
  logic [1:0]        phase;
  logic [7:0]        display;
  logic              fault;
  logic [7:0]        boards_done;

  always #10 clk_50mhz = ~clk_50mhz;

  solve_sequencer #(
    .MAX_ROWS      (MAX_ROWS),
    .MAX_COLS      (MAX_COLS),
    .LINE_W        (LINE_W),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_50mhz   (clk_50mhz),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .parsed      (parsed),
    .parse_m     (parse_m),
    .parse_n     (parse_n),
    .parse_write (parse_write),
    .parse_line  (parse_line),
    .solve_write (solve_write),
    .solve_line  (solve_line),
    .solved      (solved),
    .assembled   (assembled),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_din    (fifo_din),
    .solver_start(solver_start),
    .asm_start   (asm_start),
    .m_lat       (m_lat),
    .n_lat       (n_lat),
    .phase       (phase),
    .display     (display),
    .fault       (fault),
    .boards_done (boards_done)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit count_en = 1'b0;
  int asm_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases: 0 receive, 1 solve, 2 transmit, 3 fault. m_cyc counts the cycles
  // already spent in the current phase (0 = first cycle).
  int       m_phase;
  int       m_cyc;
  int       m_rows;
  int       m_cols;
  int       m_done;
  bit [7:0] m_disp;

  function automatic int model_next(input int p, input int cyc);
    case (p)
      0: if (parsed)
           return (int'(parse_m) >= 1 && int'(parse_m) <= MAX_ROWS &&
                   int'(parse_n) >= 1 && int'(parse_n) <= MAX_COLS) ? 1 : 3;
      1: begin
           if (solved) return 2;
           if (WD_ON && cyc >= TIMEOUT - 1) return 3;
         end
      2: if (assembled) return 0;
      3: if (rx_valid && rx_byte == 8'h1B) return 0;
      default: return 0;
    endcase
    return p;
  endfunction

  always @(posedge clk_50mhz) begin
    if (rst) begin
      m_phase <= 0;
      m_cyc   <= 0;
      m_rows  <= 0;
      m_cols  <= 0;
      m_done  <= 0;
      m_disp  <= 8'h00;
    end else begin
      m_phase <= model_next(m_phase, m_cyc);
      m_cyc   <= (model_next(m_phase, m_cyc) != m_phase) ? 0 : m_cyc + 1;
      if (rx_valid) m_disp <= rx_byte;
      if (m_phase == 0 && model_next(m_phase, m_cyc) == 1) begin
        m_rows <= int'(parse_m);
        m_cols <= int'(parse_n);
      end
      if (m_phase == 2 && assembled && m_done < 255) m_done <= m_done + 1;
    end
  end

  // Per-cycle compare on the falling edge, away from the active edge.
  always @(negedge clk_50mhz) begin
    if (chk_en) begin
      check("cyc_phase", 32'(phase), 32'(m_phase));
      check("cyc_fault", 32'(fault), 32'(m_phase == 3));
      check("cyc_solver_start", 32'(solver_start), 32'(m_phase == 1 && m_cyc == 0));
      check("cyc_asm_start", 32'(asm_start), 32'(m_phase == 2 && m_cyc == 0));
      check("cyc_m_lat", 32'(m_lat), 32'(m_rows));
      check("cyc_n_lat", 32'(n_lat), 32'(m_cols));
      check("cyc_display", 32'(display), 32'(m_disp));
      check("cyc_boards_done", 32'(boards_done), 32'(m_done));
      check("cyc_fifo_wr_en", 32'(fifo_wr_en),
            32'((m_phase == 0) ? parse_write : (m_phase == 1) ? solve_write : 1'b0));
      check("cyc_fifo_din", 32'(fifo_din),
            32'((m_phase == 0) ? parse_line : (m_phase == 1) ? solve_line : '0));
    end
  end

  always @(negedge clk_50mhz) begin
    if (!count_en) asm_cnt <= 0;
    else if (asm_start) asm_cnt <= asm_cnt + 1;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic parse_board(input int m, input int n);
    parse_m = M_W'(m);
    parse_n = N_W'(n);
    parsed  = 1'b1;
    tick();
    parsed  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0; rx_byte = 8'h00;
    parsed = 1'b0; parse_m = '0; parse_n = '0;
    parse_write = 1'b0; parse_line = '0;
    solve_write = 1'b0; solve_line = '0;
    solved = 1'b0; assembled = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_boards", 32'(boards_done), 32'd0);
    check("rst_display", 32'(display), 32'd0);
    check("rst_m_lat", 32'(m_lat), 32'd0);

    // RECEIVE: the parser owns the FIFO, solver writes are ignored
    parse_write = 1'b1; parse_line = 16'h1234;
    solve_write = 1'b1; solve_line = 16'hBEEF;
    #1;
    check("rx_fifo_en", 32'(fifo_wr_en), 32'd1);
    check("rx_fifo_din", 32'(fifo_din), 32'h1234);
    tick();
    parse_write = 1'b0; #1;
    check("rx_fifo_idle", 32'(fifo_wr_en), 32'd0);
    tick();
    parse_write = 1'b1; solve_write = 1'b0;
    parse_board(5, 5);
    check("p5_phase", 32'(phase), 32'd1);
    check("p5_solver_start", 32'(solver_start), 32'd1);
    check("p5_m_lat", 32'(m_lat), 32'd5);
    check("p5_n_lat", 32'(n_lat), 32'd5);
    check("p5_parse_blocked", 32'(fifo_wr_en), 32'd0);
    parse_write = 1'b0; solve_write = 1'b1; solve_line = 16'hCAFE; #1;
    check("solve_fifo_din", 32'(fifo_din), 32'hCAFE);
    tick();
    check("p5_start_drop", 32'(solver_start), 32'd0);

    // Spurious assembled in SOLVE, then solved
    solve_write = 1'b0;
    assembled = 1'b1; tick(); assembled = 1'b0;
    check("spur_asm_phase", 32'(phase), 32'd1);
    solved = 1'b1; tick(); solved = 1'b0;
    check("tx_phase", 32'(phase), 32'd2);
    check("tx_asm_start", 32'(asm_start), 32'd1);
    parse_write = 1'b1; solve_write = 1'b1; #1;
    check("tx_fifo_en", 32'(fifo_wr_en), 32'd0);
    check("tx_fifo_din", 32'(fifo_din), 32'd0);
    parse_board(3, 3);
    check("tx_parsed_ignored", 32'(phase), 32'd2);
    check("tx_asm_drop", 32'(asm_start), 32'd0);
    parse_write = 1'b0; solve_write = 1'b0;
    assembled = 1'b1; tick(); assembled = 1'b0;
    check("done_phase", 32'(phase), 32'd0);
    check("done_count", 32'(boards_done), 32'd1);
    solved = 1'b1; tick(); solved = 1'b0;
    check("spur_solved_phase", 32'(phase), 32'd0);
    send_byte(8'hA5);
    check("display_a5", 32'(display), 32'hA5);

    // Bad dimensions -> FAULT; only ESC leaves it
    parse_board(12, 5);
    check("bad_m_phase", 32'(phase), 32'd3);
    check("bad_m_fault", 32'(fault), 32'd1);
    check("bad_m_keep_lat", 32'(m_lat), 32'd5);
    parse_board(3, 3);
    check("fault_parsed_ignored", 32'(phase), 32'd3);
    send_byte(8'h1A);
    check("fault_not_esc", 32'(phase), 32'd3);
    check("fault_display", 32'(display), 32'h1A);
    send_byte(8'h1B);
    check("esc_phase", 32'(phase), 32'd0);
    check("esc_fault", 32'(fault), 32'd0);
    parse_board(3, 0);
    check("bad_n_phase", 32'(phase), 32'd3);
    send_byte(8'h1B);
    parse_board(11, 11);
    check("max_dim_phase", 32'(phase), 32'd1);
    check("max_dim_m_lat", 32'(m_lat), 32'd11);

    // Watchdog: 100 SOLVE cycles allowed, FAULT entered on the 100th edge
    repeat (TIMEOUT - 1) tick();
    check("wd_last_cycle", 32'(phase), 32'd1);
    tick();
    check("wd_expiry", 32'(phase), WD_ON ? 32'd3 : 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    parse_board(5, 5);
    repeat (TIMEOUT - 1) tick();
    solved = 1'b1; tick(); solved = 1'b0;
    check("wd_solved_wins", 32'(phase), 32'd2);
    assembled = 1'b1; tick(); assembled = 1'b0;

    // Reset in SOLVE with a solver write pending
    parse_board(4, 4);
    solve_write = 1'b1; solve_line = 16'h1111;
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_phase", 32'(phase), 32'd0);
    check("mid_rst_start", 32'(solver_start), 32'd0);
    check("mid_rst_m_lat", 32'(m_lat), 32'd0);
    check("mid_rst_fifo_en", 32'(fifo_wr_en), 32'd0);
    parse_write = 1'b1; parse_line = 16'h2222; #1;
    check("mid_rst_parse_en", 32'(fifo_wr_en), 32'd1);
    check("mid_rst_parse_din", 32'(fifo_din), 32'h2222);
    tick();
    parse_write = 1'b0; solve_write = 1'b0;

    // 256 full boards -> count saturates at 255
    count_en = 1'b1;
    for (int b = 0; b < 256; b++) begin
      parse_board(3, 4);
      solved = 1'b1; tick(); solved = 1'b0;
      assembled = 1'b1; tick(); assembled = 1'b0;
    end
    tick();
    check("sat_boards", 32'(boards_done), 32'd255);
    check("sat_asm_pulses", 32'(asm_cnt), 32'd256);

    chk_en = 1'b0;
    count_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
